input_debouncer: RTL and testbench
==================================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on din; legal range 2..4.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4: consecutive synchronized samples required to accept a new level; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din  input  1  raw, asynchronous, possibly bouncing level.
REQ-006 SHALL have port dout  output  1  registered, debounced level; drives the D input of the downstream flip-flop.
REQ-007 SHALL have port rise  output  1  one-cycle pulse when dout goes 0->1.
REQ-008 SHALL have port fall  output  1  one-cycle pulse when dout goes 1->0.

Function
REQ-009 SHALL pass din through a SYNC_STAGES-deep flop chain; its last stage is s, the only form of din used by the FSM.
REQ-010 SHALL implement FSM states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-011 IDLE_LOW: s=1 -> WAIT_HIGH with cnt=1; else stay, cnt=0.
REQ-012 WAIT_HIGH: s=0 -> IDLE_LOW, cnt=0 (bounce rejected); s=1 and cnt+1=STABLE_CYCLES -> IDLE_HIGH, dout=1; else cnt+1.
REQ-013 IDLE_HIGH and WAIT_LOW SHALL mirror REQ-011/012 with levels inverted; reaching IDLE_LOW sets dout=0.
REQ-014 STABLE_CYCLES=1: SHALL go directly IDLE_LOW->IDLE_HIGH (and back) on the first sample of the opposite level; WAIT states unused.
REQ-015 dout SHALL be 1 exactly in IDLE_HIGH and WAIT_LOW; dout SHALL be a flop output, never combinational.
REQ-016 Latency: din held high from before clock edge 1 -> dout=1 after edge SYNC_STAGES+STABLE_CYCLES (6 at defaults); same for falling.
REQ-017 Any s glitch shorter than STABLE_CYCLES samples SHALL leave dout unchanged and SHALL restart the count from zero.
REQ-018 cnt SHALL be $clog2(STABLE_CYCLES+1) bits, SHALL never exceed STABLE_CYCLES, and SHALL not wrap.
REQ-019 rise/fall SHALL be asserted on the same edge at which dout changes and deasserted the following edge; they SHALL never be high together.

Reset
REQ-020 reset=1 at an edge SHALL clear all sync flops, cnt=0, state=IDLE_LOW, dout=0, rise=0, fall=0, with priority over every other event.
REQ-021 Reset during a WAIT state SHALL abort the count; no pulse SHALL be emitted for the aborted transition.
REQ-022 Reset while dout=1 SHALL drive dout to 0 without a fall pulse; if din stays high, dout SHALL return to 1 per REQ-016 timing counted from the first edge with reset=0, with a rise pulse.

Configuration
REQ-023 Macro DEBOUNCE_EDGE_PULSE_EN defined: rise/fall SHALL behave per REQ-019.
REQ-024 Macro DEBOUNCE_EDGE_PULSE_EN undefined: rise and fall ports SHALL remain present, tied constant 0, with no edge-pulse logic generated; dout behaviour SHALL be identical.

Structure
REQ-025 Package debounce_pkg SHALL hold the FSM state typedef (2-bit encoding: IDLE_LOW=0, WAIT_HIGH=1, IDLE_HIGH=2, WAIT_LOW=3) and the default values of SYNC_STAGES/STABLE_CYCLES.
REQ-026 The synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, ports clk, reset, d, q), instantiated once.
REQ-027 Edge-pulse logic SHALL live inside input_debouncer under the macro guard.

Verification
REQ-028 Reset: reset=1 two cycles, din=x -> dout=0, rise=0, fall=0 at every edge while reset is high.
REQ-029 Clean rise: defaults, reset released, din=1 held -> dout=1 and rise=1 after edge 6, rise=0 after edge 7, fall never high.
REQ-030 Bounce reject: din=1 for 3 cycles, 0 for 1, then 1 held -> dout stays 0 through the glitch, rises 6 edges after the final 0->1 change, exactly one rise pulse.
REQ-031 Clean fall: from dout=1, din=0 held -> dout=0 and fall=1 after edge 6; single-cycle 1-cycle high glitch in din while low ignored.
REQ-032 Reset mid-operation: dout=1, assert reset one cycle with din=1 -> dout=0, no fall; after release dout=1 at edge 6 with rise pulse.
REQ-033 Macro off: repeat REQ-029 without DEBOUNCE_EDGE_PULSE_EN -> identical dout timing, rise=fall=0 throughout.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer.
// Holds the FSM state encoding and the default parameter values used by
// input_debouncer and its testbench.
package debounce_pkg;

  localparam int unsigned DefaultSyncStages   = 2;
  localparam int unsigned DefaultStableCycles = 4;

  // Encoding is fixed so the state can be observed and compared directly.
  typedef enum logic [1:0] {
    IdleLow  = 2'd0,
    WaitHigh = 2'd1,
    IdleHigh = 2'd2,
    WaitLow  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, clears every stage
//   d     - asynchronous input
//   q     - synchronized output (last stage)
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for a raw, asynchronous, possibly bouncing level.
// din is synchronized, then a new level is accepted only after STABLE_CYCLES
// consecutive synchronized samples of that level.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous active-high reset
//   din   - raw input level
//   dout  - registered debounced level
//   rise  - one-cycle pulse when dout goes 0->1
//   fall  - one-cycle pulse when dout goes 1->0
// Configuration:
//   DEBOUNCE_EDGE_PULSE_EN - when defined, rise/fall are generated; otherwise
//   both ports are tied to 0.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DefaultSyncStages,
  parameter int unsigned STABLE_CYCLES = DefaultStableCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] StableCnt = CntW'(STABLE_CYCLES);

  logic            s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            dout_q, dout_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (s)
  );

  // Only evaluated in WAIT states where cnt_q < STABLE_CYCLES, so it never wraps.
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IdleLow: begin
        cnt_d = '0;
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IdleHigh;
          end else begin
            state_d = WaitHigh;
            cnt_d   = CntW'(1);
          end
        end
      end
      WaitHigh: begin
        if (!s) begin
          state_d = IdleLow;
          cnt_d   = '0;
        end else if (cnt_inc == StableCnt) begin
          state_d = IdleHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IdleHigh: begin
        cnt_d = '0;
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IdleLow;
          end else begin
            state_d = WaitLow;
            cnt_d   = CntW'(1);
          end
        end
      end
      WaitLow: begin
        if (s) begin
          state_d = IdleHigh;
          cnt_d   = '0;
        end else if (cnt_inc == StableCnt) begin
          state_d = IdleLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IdleLow;
        cnt_d   = '0;
      end
    endcase
    // dout is high exactly while the accepted level is high.
    dout_d = (state_d == IdleHigh) || (state_d == WaitLow);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IdleLow;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Pulses register alongside dout so they change on the same edge.
  always_comb begin
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  // Reset forces dout low without a fall pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer. Expected per-edge outputs are
// derived from the latency rules, queued, then popped and compared #1 after
// each rising edge. A second instance covers STABLE_CYCLES=1 / SYNC_STAGES=3.
module tb_input_debouncer;

  localparam int SyncStages = 2;
  localparam int StableCyc  = 4;
  localparam int Lat        = SyncStages + StableCyc;
  localparam int Lat1       = 3 + 1;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit PulseEn = 1'b1;
`else
  localparam bit PulseEn = 1'b0;
`endif

  typedef struct packed {
    logic dout;
    logic rise;
    logic fall;
  } exp_t;

  logic clk;
  logic reset;
  logic din;
  logic dout, rise, fall;
  logic dout1, rise1, fall1;

  int checks;
  int errors;
  exp_t exp_q[$];

  input_debouncer #(
    .SYNC_STAGES   (SyncStages),
    .STABLE_CYCLES (StableCyc)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall)
  );

  input_debouncer #(
    .SYNC_STAGES   (3),
    .STABLE_CYCLES (1)
  ) u_dut_s1 (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout1),
    .rise  (rise1),
    .fall  (fall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input logic d, input logic r, input logic f);
    exp_t e;
    e.dout = d;
    e.rise = r & PulseEn;
    e.fall = f & PulseEn;
    exp_q.push_back(e);
  endfunction

  // Two reset edges with din low; the next edge is the first with reset=0.
  task automatic apply_reset();
    reset = 1'b1;
    din   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got, e;
    reset = 1'b1;
    din   = 1'bx;
    for (int i = 1; i <= 2; i++) push(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk);
      #1;
      got = {dout, rise, fall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset edge %0d: got dout,rise,fall=%b expected %b", i, got, e);
      end
    end
    din   = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_clean_rise();
    exp_t got, e;
    apply_reset();
    for (int i = 1; i <= 9; i++) push(i >= Lat, i == Lat, 1'b0);
    din = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      got = {dout, rise, fall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL clean_rise edge %0d: got dout,rise,fall=%b expected %b", i, got, e);
      end
    end
  endtask

  // din: 1,1,1,0 then 1 held; final 0->1 lands before edge 5, so dout at 5+Lat-1.
  task automatic test_bounce();
    exp_t got, e;
    apply_reset();
    for (int i = 1; i <= 12; i++) push(i >= 4 + Lat, i == 4 + Lat, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      din = (i == 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      got = {dout, rise, fall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL bounce edge %0d: got dout,rise,fall=%b expected %b", i, got, e);
      end
    end
  endtask

  // Starts from dout=1; a one-cycle high glitch before edge 9 must be ignored.
  task automatic test_clean_fall();
    exp_t got, e;
    for (int i = 1; i <= 16; i++) push(i < Lat, 1'b0, i == Lat);
    for (int i = 1; i <= 16; i++) begin
      din = (i == 9) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      got = {dout, rise, fall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL clean_fall edge %0d: got dout,rise,fall=%b expected %b", i, got, e);
      end
    end
  endtask

  // Rise, one reset edge with din high (no fall), then rise again after release.
  task automatic test_reset_mid();
    exp_t got, e;
    int j;
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      j = (i <= 8) ? i : i - 9;
      if (i == 9) push(1'b0, 1'b0, 1'b0);
      else push(j >= Lat, j == Lat, 1'b0);
    end
    din = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      reset = (i == 9);
      @(posedge clk);
      #1;
      got = {dout, rise, fall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid edge %0d: got dout,rise,fall=%b expected %b", i, got, e);
      end
    end
    reset = 1'b0;
  endtask

  // Reset at edge 5 while counting in WaitHigh; count restarts from edge 6.
  task automatic test_reset_wait();
    exp_t got, e;
    apply_reset();
    for (int i = 1; i <= 13; i++) push(i >= 5 + Lat, i == 5 + Lat, 1'b0);
    din = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      reset = (i == 5);
      @(posedge clk);
      #1;
      got = {dout, rise, fall};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_wait edge %0d: got dout,rise,fall=%b expected %b", i, got, e);
      end
    end
    reset = 1'b0;
  endtask

  // STABLE_CYCLES=1, SYNC_STAGES=3: level accepted on first opposite sample.
  task automatic test_stable1();
    exp_t got, e;
    int j;
    apply_reset();
    for (int i = 1; i <= 12; i++) begin
      j = (i <= 6) ? i : i - 6;
      if (i <= 6) push(j >= Lat1, j == Lat1, 1'b0);
      else push(j < Lat1, 1'b0, j == Lat1);
    end
    for (int i = 1; i <= 12; i++) begin
      din = (i <= 6);
      @(posedge clk);
      #1;
      got = {dout1, rise1, fall1};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stable1 edge %0d: got dout,rise,fall=%b expected %b", i, got, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    din    = 1'b0;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_clean_fall();
    test_reset_mid();
    test_reset_wait();
    test_stable1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
